// File: rtl/ysyx_22040127_imem_pkg.sv
// Shared types and constants for the instruction-memory responder.
package ysyx_22040127_imem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [31:0] DEFAULT_BASE = 32'h8000_0000;
    localparam int          CNT_W        = 4;

    // Counter preload so that the last WAIT cycle is the one with count 1.
    function automatic logic [CNT_W-1:0] cnt_load(input int latency);
        return CNT_W'(latency - 1);
    endfunction

endpackage

// File: rtl/ysyx_22040127_imem_array.sv
// Doubleword storage: one registered read port, one write port, read-before-write.
module ysyx_22040127_imem_array #(
    parameter int DEPTH_LOG2 = 12,
    parameter int DATA_W     = 64
) (
    input  logic                  clk,
    input  logic                  rd_en,
    input  logic [DEPTH_LOG2-1:0] rd_idx,
    output logic [DATA_W-1:0]     rd_data,
    input  logic                  wr_en,
    input  logic [DEPTH_LOG2-1:0] wr_idx,
    input  logic [DATA_W-1:0]     wr_data
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_data_reg;

    // Both ports in one block: a same-address read sees the pre-write contents.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
        if (rd_en) begin
            rd_data_reg <= mem[rd_idx];
        end
    end

    assign rd_data = rd_data_reg;

endmodule

// File: rtl/ysyx_22040127_imem_responder.sv
// Memory-side end of the fetch interface: fixed-latency doubleword lookup with
// valid/ready request and response handshakes, flush and preload port.
module ysyx_22040127_imem_responder
    import ysyx_22040127_imem_pkg::*;
#(
    parameter int                ADDR_W     = 32,
    parameter int                DATA_W     = 64,
    parameter int                DEPTH_LOG2 = 12,
    parameter logic [ADDR_W-1:0] BASE       = ADDR_W'(DEFAULT_BASE),
    parameter int                LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_W-1:0]     req_addr,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_W-1:0]     resp_data,
    output logic [ADDR_W-1:0]     resp_addr,
    output logic                  resp_err,
    input  logic                  flush,
    input  logic                  ld_en,
    input  logic [DEPTH_LOG2-1:0] ld_idx,
    input  logic [DATA_W-1:0]     ld_data
);

    localparam bit               SINGLE   = (LATENCY == 1);
    localparam logic [CNT_W-1:0] CNT_INIT = cnt_load(LATENCY);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam state_t           START    = SINGLE ? RESP : WAIT;

    state_t                  state_reg;
    state_t                  state_next;
    logic [CNT_W-1:0]        cnt_reg;
    logic [ADDR_W-1:0]       addr_reg;
    logic                    err_reg;
    logic [DEPTH_LOG2-1:0]   idx_reg;
    logic                    data_sel_reg;

    logic                    accept;
    logic                    sample;
    logic                    sample_err;
    logic                    rd_en;
    logic [DEPTH_LOG2-1:0]   rd_idx;
    logic [DATA_W-1:0]       rd_data;

    logic [ADDR_W:0]         diff_ext;
    logic                    below_base;
    logic                    out_of_range;
    logic                    misaligned;
    logic                    req_err;
    logic [DEPTH_LOG2-1:0]   req_idx;
    logic                    unused_low_bits;

    // Address check: the extra top bit of the subtraction is the borrow.
    assign diff_ext        = {1'b0, req_addr} - {1'b0, BASE};
    assign below_base      = diff_ext[ADDR_W];
    assign out_of_range    = |diff_ext[ADDR_W-1:DEPTH_LOG2+3];
    assign misaligned      = |req_addr[1:0];
    assign req_err         = below_base | out_of_range | misaligned;
    assign req_idx         = diff_ext[DEPTH_LOG2+2:3];
    assign unused_low_bits = ^diff_ext[2:0];

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; flush overrides everything outside IDLE.
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next = START;
                end
            end
            WAIT: begin
                if (flush) begin
                    state_next = IDLE;
                end else if (cnt_reg == CNT_ONE) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                if (flush) begin
                    state_next = IDLE;
                end else if (resp_ready) begin
                    state_next = accept ? START : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Handshake outputs
    always_comb begin
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        if (!rst) begin
            req_ready = (state_reg == IDLE) ||
                        ((state_reg == RESP) && resp_ready && !flush);
        end
        resp_valid = (state_reg == RESP) && !flush;
    end

    assign accept = req_valid && req_ready;

    // The array is sampled on the edge that enters RESP; errored accesses skip the read.
    assign sample     = (SINGLE && accept) ||
                        ((state_reg == WAIT) && !flush && (cnt_reg == CNT_ONE));
    assign sample_err = (state_reg == WAIT) ? err_reg : req_err;
    assign rd_en      = sample && !sample_err;
    assign rd_idx     = (state_reg == WAIT) ? idx_reg : req_idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg      <= '0;
            addr_reg     <= '0;
            err_reg      <= 1'b0;
            idx_reg      <= '0;
            data_sel_reg <= 1'b0;
        end else begin
            if (accept) begin
                addr_reg <= req_addr;
                err_reg  <= req_err;
                idx_reg  <= req_idx;
                cnt_reg  <= CNT_INIT;
            end else if (state_reg == WAIT) begin
                cnt_reg <= flush ? '0 : cnt_reg - CNT_ONE;
            end
            if (sample) begin
                data_sel_reg <= !sample_err;
            end
        end
    end

    assign resp_data = data_sel_reg ? rd_data : '0;
    assign resp_addr = addr_reg;
    assign resp_err  = err_reg;

    ysyx_22040127_imem_array #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .DATA_W     (DATA_W)
    ) u_array (
        .clk     (clk),
        .rd_en   (rd_en),
        .rd_idx  (rd_idx),
        .rd_data (rd_data),
        .wr_en   (ld_en),
        .wr_idx  (ld_idx),
        .wr_data (ld_data)
    );

endmodule

// File: tb/tb_ysyx_22040127_imem_responder.sv
// Directed bench with a cycle-timed transaction model checked on every negedge.
module tb_ysyx_22040127_imem_responder;

    localparam int          LAT  = 2;
    localparam logic [31:0] BASE = 32'h8000_0000;
    localparam logic [63:0] W0   = 64'h0000_0013_0010_0073;
    localparam logic [63:0] W1   = 64'h1111_2222_3333_4444;
    localparam logic [63:0] WA   = 64'hAAAA_AAAA_0000_0001;
    localparam logic [63:0] WB   = 64'hBBBB_BBBB_0000_0002;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [63:0] resp_data;
    logic [31:0] resp_addr;
    logic        resp_err;
    logic        flush = 1'b0;
    logic        ld_en = 1'b0;
    logic [11:0] ld_idx = '0;
    logic [63:0] ld_data = '0;

    int n_checks = 0;
    int n_err    = 0;

    ysyx_22040127_imem_responder #(
        .ADDR_W(32), .DATA_W(64), .DEPTH_LOG2(12), .BASE(BASE), .LATENCY(LAT)
    ) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_addr(resp_addr), .resp_err(resp_err),
        .flush(flush), .ld_en(ld_en), .ld_idx(ld_idx), .ld_data(ld_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_err++;
        $display("FAIL %s: actual=timeout required=event", name);
    endtask

    // Model: one outstanding transaction, response due from edge accept+LAT-1.
    logic [63:0] shadow [4096];
    bit          m_busy   = 1'b0;
    int          m_sample = 0;
    bit          m_err    = 1'b0;
    int          m_idx    = 0;
    logic [31:0] m_addr   = '0;
    logic [63:0] m_data   = '0;
    int          edge_n   = 0;

    initial begin
        for (int i = 0; i < 4096; i++) shadow[i] = '0;
    end

    initial forever begin
        bit     in_resp, rr, acc;
        longint off;
        @(posedge clk);
        edge_n++;
        if (rst) begin
            m_busy = 1'b0;
        end else begin
            in_resp = m_busy && (edge_n > m_sample);
            rr      = !m_busy || (in_resp && resp_ready && !flush);
            acc     = req_valid && rr;
            if (m_busy && flush) m_busy = 1'b0;
            else if (in_resp && resp_ready) m_busy = 1'b0;
            if (m_busy && edge_n == m_sample) m_data = m_err ? 64'd0 : shadow[m_idx];
            if (acc) begin
                off      = longint'(req_addr) - longint'(BASE);
                m_err    = (off < 0) || ((off >>> 3) >= 4096) || (req_addr[1:0] != 2'b00);
                m_idx    = m_err ? 0 : int'(off >>> 3);
                m_addr   = req_addr;
                m_busy   = 1'b1;
                m_sample = edge_n + LAT - 1;
                if (LAT == 1) m_data = m_err ? 64'd0 : shadow[m_idx];
            end
            if (ld_en) shadow[ld_idx] = ld_data;
        end
    end

    initial forever begin
        bit in_resp, exp_rr, exp_rv;
        @(negedge clk);
        in_resp = m_busy && (edge_n >= m_sample);
        exp_rr  = !rst && (!m_busy || (in_resp && resp_ready && !flush));
        exp_rv  = !rst && in_resp && !flush;
        chk("model_req_ready", 64'(req_ready), 64'(exp_rr));
        chk("model_resp_valid", 64'(resp_valid), 64'(exp_rv));
        if (exp_rv) begin
            chk("model_resp_data", resp_data, m_data);
            chk("model_resp_addr", 64'(resp_addr), 64'(m_addr));
            chk("model_resp_err", 64'(resp_err), 64'(m_err));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [11:0] idx, input logic [63:0] d);
        ld_en = 1'b1; ld_idx = idx; ld_data = d;
        tick();
        ld_en = 1'b0;
    endtask

    task automatic issue(input logic [31:0] a);
        bit acc;
        req_valid = 1'b1;
        req_addr  = a;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            acc = req_ready;
            tick();
            if (acc) begin
                req_valid = 1'b0;
                return;
            end
        end
        req_valid = 1'b0;
        timeout("accept");
    endtask

    task automatic wait_resp(output int n);
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (resp_valid) begin
                n = i;
                return;
            end
        end
        timeout("resp_wait");
    endtask

    logic [31:0] eaddr [3];
    int n;

    initial begin
        eaddr[0] = 32'h7FFF_FFF8;
        eaddr[1] = 32'h8000_0002;
        eaddr[2] = BASE + 32'h0000_8000;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_resp_data", resp_data, 64'd0);
        chk("rst_resp_addr", 64'(resp_addr), 64'd0);
        chk("rst_resp_err", 64'(resp_err), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rel_req_ready", 64'(req_ready), 64'd1);
        tick();

        // Basic fetch
        preload(12'd0, W0);
        preload(12'd1, W1);
        issue(32'h8000_0000);
        wait_resp(n);
        chk("basic_latency", 64'(n), 64'd2);
        chk("basic_data", resp_data, W0);
        chk("basic_addr", 64'(resp_addr), 64'h8000_0000);
        chk("basic_err", 64'(resp_err), 64'd0);
        tick();

        // Back-to-back with backpressure
        resp_ready = 1'b0;
        issue(32'h8000_0004);
        req_valid = 1'b1;
        req_addr  = 32'h8000_0008;
        wait_resp(n);
        for (int k = 0; k < 3; k++) begin
            chk("b2b_hold_ready", 64'(req_ready), 64'd0);
            chk("b2b_hold_data", resp_data, W0);
            chk("b2b_hold_addr", 64'(resp_addr), 64'h8000_0004);
            @(negedge clk);
        end
        @(posedge clk); #1;
        resp_ready = 1'b1;
        @(negedge clk);
        chk("b2b_ready_on_hs", 64'(req_ready), 64'd1);
        tick();
        req_valid = 1'b0;
        wait_resp(n);
        chk("b2b_second_latency", 64'(n), 64'd2);
        chk("b2b_second_data", resp_data, W1);
        chk("b2b_second_addr", 64'(resp_addr), 64'h8000_0008);
        tick();

        // Error responses
        for (int e = 0; e < 3; e++) begin
            issue(eaddr[e]);
            wait_resp(n);
            chk("err_flag", 64'(resp_err), 64'd1);
            chk("err_data", resp_data, 64'd0);
            chk("err_addr", 64'(resp_addr), 64'(eaddr[e]));
            tick();
        end

        // Flush in WAIT
        issue(32'h8000_0000);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        @(negedge clk);
        chk("flush_wait_valid", 64'(resp_valid), 64'd0);
        chk("flush_wait_idle", 64'(req_ready), 64'd1);
        repeat (3) begin
            @(negedge clk);
            chk("flush_wait_quiet", 64'(resp_valid), 64'd0);
        end
        tick();

        // Flush in RESP with resp_ready high
        issue(32'h8000_0000);
        wait_resp(n);
        #2 flush = 1'b1;
        #1;
        chk("flush_resp_valid", 64'(resp_valid), 64'd0);
        chk("flush_resp_ready", 64'(req_ready), 64'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        chk("flush_resp_idle", 64'(req_ready), 64'd1);
        chk("flush_resp_gone", 64'(resp_valid), 64'd0);
        tick();

        // Flush in IDLE with a request: request completes
        flush = 1'b1; req_valid = 1'b1; req_addr = 32'h8000_0008;
        tick();
        flush = 1'b0; req_valid = 1'b0;
        wait_resp(n);
        chk("flush_idle_data", resp_data, W1);
        chk("flush_idle_addr", 64'(resp_addr), 64'h8000_0008);
        tick();

        // Collision: write on the sampling edge returns the old word
        preload(12'd3, WA);
        issue(32'h8000_0018);
        ld_en = 1'b1; ld_idx = 12'd3; ld_data = WB;
        tick();
        ld_en = 1'b0;
        wait_resp(n);
        chk("coll_old_data", resp_data, WA);
        tick();
        issue(32'h8000_0018);
        wait_resp(n);
        chk("coll_new_data", resp_data, WB);
        tick();

        // Reset during WAIT
        issue(32'h8000_0000);
        #2 rst = 1'b1;
        #1;
        chk("rstmid_valid", 64'(resp_valid), 64'd0);
        chk("rstmid_ready", 64'(req_ready), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rstmid_ready_after", 64'(req_ready), 64'd1);
        repeat (4) begin
            @(negedge clk);
            chk("rstmid_no_stale", 64'(resp_valid), 64'd0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
